actfun_sched: RTL and testbench

//  Group-level sequencer for the activation-function input AGU.

---
 rtl/npu_actfun_pkg.sv | 17 +
 rtl/actfun_sched.sv | 156 +++++++++++++++
 tb/tb_actfun_sched.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/npu_actfun_pkg.sv
// Shared definitions for the activation-function input sequencing blocks:
// default bus widths and the group sequencer's state encoding.
package npu_actfun_pkg;

  localparam int DEF_ADDR_W    = 12;
  localparam int DEF_PIECE_W   = 8;
  localparam int DEF_GRP_W     = 8;
  localparam int DEF_DRAIN_CYC = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/actfun_sched.sv
// Group-level sequencer for the actfun input AGU: one start pulse per group, burst-end
// detection on i_agu_ren, then a fixed drain. Optional ACTFUN_SCHED_PERF_EN adds o_perf_cyc.
module actfun_sched
  import npu_actfun_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int PIECE_W   = DEF_PIECE_W,
  parameter int GRP_W     = DEF_GRP_W,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [ADDR_W-1:0]  i_cmd_addr_base,
  input  logic [PIECE_W-1:0] i_cmd_piece_num,
  input  logic [GRP_W-1:0]   i_cmd_grp_num,
  input  logic [ADDR_W-1:0]  i_cmd_grp_stride,
  input  logic               i_abort,
  input  logic               i_agu_ren,
  output logic               o_agu_start,
  output logic [ADDR_W-1:0]  o_agu_addr_start,
  output logic [PIECE_W-1:0] o_agu_piece_num,
  output logic [GRP_W-1:0]   o_grp_idx,
  output logic               o_busy,
  output logic               o_done
`ifdef ACTFUN_SCHED_PERF_EN
  ,
  output logic [31:0]        o_perf_cyc
`endif
);

  localparam int                DCNT_W     = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYC - 1);
  localparam logic [DCNT_W-1:0] DCNT_ONE   = DCNT_W'(1);
  localparam logic [GRP_W-1:0]  GRP_ONE    = GRP_W'(1);

  state_e              state;
  logic [GRP_W-1:0]    grp_num;
  logic [ADDR_W-1:0]   stride;
  logic [DCNT_W-1:0]   drain_cnt;
  logic                seen_ren;
  logic                start_q;
  logic                zero_cmd;
  logic                accept;
  logic                last_grp;

  assign o_cmd_ready = (state == S_IDLE) && !i_abort;
  assign accept      = o_cmd_ready && i_cmd_valid;
  assign last_grp    = (o_grp_idx == grp_num - GRP_ONE);
  // Abort must kill a start pulse already registered for this cycle.
  assign o_agu_start = start_q && !i_abort;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // branch reads the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= S_IDLE;
      grp_num          <= '0;
      stride           <= '0;
      drain_cnt        <= '0;
      seen_ren         <= 1'b0;
      start_q          <= 1'b0;
      zero_cmd         <= 1'b0;
      o_agu_addr_start <= '0;
      o_agu_piece_num  <= '0;
      o_grp_idx        <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
    end else begin
      start_q <= 1'b0;
      o_done  <= 1'b0;
      if (i_abort) begin
        state  <= S_IDLE;
        o_busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (accept) begin
            o_agu_piece_num  <= i_cmd_piece_num;
            grp_num          <= i_cmd_grp_num;
            stride           <= i_cmd_grp_stride;
            o_agu_addr_start <= i_cmd_addr_base;
            o_grp_idx        <= '0;
            o_busy           <= 1'b1;
            // A zero-length burst would wrap the AGU counter, so finish without starting it.
            if (i_cmd_piece_num == '0 || i_cmd_grp_num == '0) begin
              zero_cmd <= 1'b1;
              o_done   <= 1'b1;
              state    <= S_DRAIN;
            end else begin
              zero_cmd <= 1'b0;
              start_q  <= 1'b1;
              state    <= S_START;
            end
          end
          S_START: begin
            seen_ren <= 1'b0;
            state    <= S_RUN;
          end
          S_RUN: begin
            if (i_agu_ren) begin
              seen_ren <= 1'b1;
            end else if (seen_ren) begin
              drain_cnt <= DRAIN_LOAD;
              state     <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (zero_cmd) begin
              zero_cmd <= 1'b0;
              o_busy   <= 1'b0;
              state    <= S_IDLE;
            end else if (drain_cnt != '0) begin
              drain_cnt <= drain_cnt - DCNT_ONE;
            end else if (last_grp) begin
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end else begin
              o_agu_addr_start <= o_agu_addr_start + stride;
              o_grp_idx        <= o_grp_idx + GRP_ONE;
              start_q          <= 1'b1;
              state            <= S_START;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef ACTFUN_SCHED_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                        o_perf_cyc <= '0;
    else if (accept)                     o_perf_cyc <= '0;
    else if (o_busy && o_perf_cyc != '1) o_perf_cyc <= o_perf_cyc + 32'd1;
  end
`endif

`ifndef SYNTHESIS
  // Burst-length cross-check against the AGU: simulation only.
  logic [PIECE_W:0] ren_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ren_cnt <= '0;
    end else begin
      if (state == S_START)                 ren_cnt <= '0;
      else if (state == S_RUN && i_agu_ren) ren_cnt <= ren_cnt + (PIECE_W+1)'(1);
      if (!i_abort && state == S_RUN && seen_ren && !i_agu_ren)
        assert (ren_cnt == {1'b0, o_agu_piece_num})
          else $error("actfun_sched: AGU burst length %0d, expected %0d", ren_cnt, o_agu_piece_num);
    end
  end
`endif

endmodule

// File: tb/tb_actfun_sched.sv
// Self-checking bench for actfun_sched with a behavioural AGU model; define
// ACTFUN_SCHED_PERF_EN on both RTL and bench to also check o_perf_cyc.
module tb_actfun_sched;

  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, abort_i, agu_ren, agu_start, busy, done;
  logic [11:0] cmd_base, cmd_stride, agu_addr;
  logic [7:0]  cmd_p, cmd_g, agu_pn, grp_idx;
`ifdef ACTFUN_SCHED_PERF_EN
  logic [31:0] perf_cyc;
`endif

  always #5 clk = ~clk;

  actfun_sched #(.DRAIN_CYC(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_addr_base(cmd_base), .i_cmd_piece_num(cmd_p),
    .i_cmd_grp_num(cmd_g), .i_cmd_grp_stride(cmd_stride),
    .i_abort(abort_i), .i_agu_ren(agu_ren),
    .o_agu_start(agu_start), .o_agu_addr_start(agu_addr),
    .o_agu_piece_num(agu_pn), .o_grp_idx(grp_idx),
    .o_busy(busy), .o_done(done)
`ifdef ACTFUN_SCHED_PERF_EN
    , .o_perf_cyc(perf_cyc)
`endif
  );

  // AGU model: P read-enable cycles beginning the cycle after the start pulse.
  int agu_left;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)              agu_left <= 0;
    else if (agu_start)      agu_left <= int'(agu_pn);
    else if (agu_left > 0)   agu_left <= agu_left - 1;
  end
  assign agu_ren = (agu_left != 0);

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int model_addr(input logic [11:0] base, input logic [11:0] stride, input int k);
    return (int'(base) + k * int'(stride)) % 4096;
  endfunction

  // Issue one command and observe it to completion, comparing against expectations.
  task automatic run_cmd(input string tag, input logic [11:0] base, input logic [7:0] p,
                         input logic [7:0] g, input logic [11:0] stride,
                         input int exp_starts, input int exp_busy, input logic [11:0] exp_last);
    int starts = 0, dones = 0, busy_cyc = 0, done_at = -1, ren_cyc = 0;
    int addr_bad = 0, idx_bad = 0, pn_bad = 0, gap_bad = 0;
    int fall_at = -1, cyc = 0, idle_run = 0;
    bit prev_ren = 1'b0;
    logic [11:0] last_addr = 12'h0;
    @(negedge clk);
    check({tag, " ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_base = base; cmd_p = p; cmd_g = g; cmd_stride = stride;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    while (idle_run < 4 && cyc < exp_busy + 40) begin
      @(negedge clk);
      cyc++;
      if (busy) begin busy_cyc++; idle_run = 0; end
      else idle_run++;
      if (done) begin dones++; done_at = cyc; end
      if (agu_start) begin
        if (int'(agu_addr) != model_addr(base, stride, starts)) addr_bad++;
        if (int'(grp_idx) != starts) idx_bad++;
        if (agu_pn != p) pn_bad++;
        if (fall_at >= 0 && cyc - fall_at != D + 1) gap_bad++;
        fall_at = -1;
        last_addr = agu_addr;
        starts++;
      end
      if (agu_ren) ren_cyc++;
      if (prev_ren && !agu_ren) fall_at = cyc;
      prev_ren = agu_ren;
    end
    check({tag, " completed_in_budget"}, idle_run >= 4, 1);
    check({tag, " start_pulses"}, starts, exp_starts);
    check({tag, " done_pulses"}, dones, 1);
    check({tag, " busy_cycles"}, busy_cyc, exp_busy);
    check({tag, " done_cycle"}, done_at, (exp_starts == 0) ? 1 : exp_busy + 1);
    check({tag, " ren_cycles"}, ren_cyc, exp_starts * int'(p));
    check({tag, " bad_start_addr"}, addr_bad, 0);
    check({tag, " bad_grp_idx"}, idx_bad, 0);
    check({tag, " bad_piece_num"}, pn_bad, 0);
    check({tag, " bad_drain_gap"}, gap_bad, 0);
    if (exp_starts > 0) check({tag, " last_start_addr"}, last_addr, exp_last);
`ifdef ACTFUN_SCHED_PERF_EN
    check({tag, " perf_cyc"}, perf_cyc, busy_cyc);
`endif
  endtask

  typedef struct {
    logic [11:0] base;
    logic [7:0]  p;
    logic [7:0]  g;
    logic [11:0] stride;
    int          exp_starts;
    int          exp_busy;
    logic [11:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int starts, dones, waited, ready_bad;
    logic [11:0] seen_addr[$];
    logic [11:0] rb, rs, rl;
    logic [7:0]  rp, rg;
    int          es, eb;

    vecs[0] = '{12'h100, 8'd4, 8'd3, 12'h010, 3, 27, 12'h120};
    vecs[1] = '{12'hFF8, 8'd8, 8'd2, 12'h010, 2, 26, 12'h008};
    vecs[2] = '{12'h055, 8'd0, 8'd5, 12'h100, 0, 1,  12'h055};
    vecs[3] = '{12'h3C0, 8'd5, 8'd0, 12'h020, 0, 1,  12'h3C0};
    vecs[4] = '{12'hABC, 8'd1, 8'd1, 12'h000, 1, 6,  12'hABC};
    vecs[5] = '{12'h040, 8'd2, 8'd1, 12'h004, 1, 7,  12'h040};

    rst_n = 1'b0; cmd_valid = 1'b0; abort_i = 1'b0;
    cmd_base = '0; cmd_p = '0; cmd_g = '0; cmd_stride = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset agu_start", agu_start, 0);
    check("reset addr", agu_addr, 0);
    check("reset piece", agu_pn, 0);
    check("reset grp_idx", grp_idx, 0);
    check("reset ready", cmd_ready, 1);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_cmd($sformatf("vec%0d", i), vecs[i].base, vecs[i].p, vecs[i].g, vecs[i].stride,
              vecs[i].exp_starts, vecs[i].exp_busy, vecs[i].exp_last);

    // Abort during RUN of group 1 of 3.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 12'h200; cmd_p = 8'd6; cmd_g = 8'd3; cmd_stride = 12'h040;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!(grp_idx == 8'd1 && agu_ren) && waited < 100);
    check("abort reached_grp1_run", waited < 100, 1);
    abort_i = 1'b1;
    @(negedge clk);
    check("abort busy_low", busy, 0);
    check("abort no_done", done, 0);
    check("abort ready_low_while_abort", cmd_ready, 0);
    abort_i = 1'b0;
    #1;
    check("abort ready_returns", cmd_ready, 1);
    starts = 0; dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (agu_start) starts++;
      if (done || busy) dones++;
    end
    check("abort no_more_starts", starts, 0);
    check("abort no_done_or_busy_after", dones, 0);

    // Valid together with abort in IDLE: not accepted.
    @(negedge clk);
    cmd_valid = 1'b1; abort_i = 1'b1; cmd_base = 12'h5A5; cmd_p = 8'd3; cmd_g = 8'd1;
    #1;
    check("valid+abort ready", cmd_ready, 0);
    @(negedge clk);
    check("valid+abort not_busy", busy, 0);
    cmd_valid = 1'b0; abort_i = 1'b0;
    @(negedge clk);
    check("valid+abort still_idle", busy, 0);
    run_cmd("after_abort", 12'h5A5, 8'd3, 8'd1, 12'h000, 1, 8, 12'h5A5);

    // Valid held while busy: only taken once the first command completes.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 12'h300; cmd_p = 8'd2; cmd_g = 8'd1; cmd_stride = 12'h0;
    @(posedge clk); #1;
    cmd_base = 12'h777; cmd_p = 8'd1;
    dones = 0; ready_bad = 0; waited = 0;
    while (dones < 2 && waited < 80) begin
      @(negedge clk); waited++;
      if (busy && cmd_ready) ready_bad++;
      if (done) dones++;
      if (agu_start) begin
        seen_addr.push_back(agu_addr);
        if (agu_addr == 12'h777) cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check("held dones", dones, 2);
    check("held ready_while_busy", ready_bad, 0);
    check("held start_count", seen_addr.size(), 2);
    if (seen_addr.size() == 2) begin
      check("held first_addr", seen_addr[0], 12'h300);
      check("held second_addr", seen_addr[1], 12'h777);
    end
    repeat (5) @(negedge clk);

    // Randomized commands against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      rb = 12'($urandom_range(0, 4095));
      rs = 12'($urandom_range(0, 4095));
      rp = 8'($urandom_range(0, 12));
      rg = 8'($urandom_range(0, 4));
      if (rp == 0 || rg == 0) begin
        es = 0; eb = 1; rl = rb;
      end else begin
        es = int'(rg);
        eb = int'(rg) * (int'(rp) + 2 + D);
        rl = 12'(model_addr(rb, rs, int'(rg) - 1));
      end
      run_cmd($sformatf("rand%0d", i), rb, rp, rg, rs, es, eb, rl);
    end

    // Asynchronous reset in the middle of a burst.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_base = 12'h0F0; cmd_p = 8'd10; cmd_g = 8'd2; cmd_stride = 12'h010;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    waited = 0;
    do begin @(negedge clk); waited++; end while (!agu_ren && waited < 50);
    check("areset reached_run", waited < 50, 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset busy", busy, 0);
    check("areset done", done, 0);
    check("areset agu_start", agu_start, 0);
    check("areset addr", agu_addr, 0);
    check("areset piece", agu_pn, 0);
    check("areset grp_idx", grp_idx, 0);
    check("areset ready", cmd_ready, 1);
`ifdef ACTFUN_SCHED_PERF_EN
    check("areset perf", perf_cyc, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_cmd("post_reset", 12'h010, 8'd2, 8'd2, 12'h100, 2, 14, 12'h110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
